mem_pipe: RTL and testbench

MEM_PIPE -- requirements
Module: mem_pipe

---
 rtl/mem_pipe_pkg.sv | 12 +
 rtl/mem_pipe_fifo.sv | 54 +++++
 rtl/mem_pipe.sv | 182 ++++++++++++++++++
 tb/tb_mem_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pipe_pkg.sv
// Shared types and constants for the mem_pipe read-pipelined memory.
package mem_pipe_pkg;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

endpackage

// File: rtl/mem_pipe_fifo.sv
// Output buffer for mem_pipe: first-word-fall-through FIFO. When empty, an
// incoming word is presented immediately and is only stored if not consumed.
module mem_pipe_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             do_store;
  logic             pop_stored;

  assign empty      = (count == '0);
  assign valid      = !empty || push;
  assign data       = empty ? push_data : mem[rd_ptr];
  assign do_store   = push && !(empty && ready);
  assign pop_stored = !empty && ready;

  always_ff @(posedge clk) begin
    if (do_store) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_store)   wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_stored) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_store, pop_stored})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_pipe.sv
// Byte-writable memory with a credit-controlled, latency-padded read pipeline.
// States: INIT | zero-fill sweep, busy=1 ; RUN | normal read/write service
module mem_pipe
  import mem_pipe_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_ADDRESSES   = 1024,
  parameter int LOG_MAX_ADDRESS = 10,
  parameter int READ_LATENCY    = 2,
  parameter int INIT_ON_RESET   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      data_write,
  input  logic [DATA_WIDTH/8-1:0]    be_write,
  input  logic [LOG_MAX_ADDRESS-1:0] addr_write,
  input  logic                       write,
  input  logic [LOG_MAX_ADDRESS-1:0] addr_read,
  input  logic                       read,
  output logic                       read_ready,
  output logic [DATA_WIDTH-1:0]      data_read,
  output logic                       valid_out,
  input  logic                       ready_in,
  output logic                       busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = READ_LATENCY + 1;
  localparam int OW    = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] CAP = OW'(DEPTH);
  localparam logic [LOG_MAX_ADDRESS:0]   ADDR_LIMIT = (LOG_MAX_ADDRESS + 1)'(NUM_ADDRESSES);
  localparam logic [LOG_MAX_ADDRESS-1:0] LAST_ADDR  = LOG_MAX_ADDRESS'(NUM_ADDRESSES - 1);

  generate
    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
      $error("mem_pipe: READ_LATENCY outside supported range");
    end
  endgenerate

  ctrl_state_t                state_q, state_d;
  logic [LOG_MAX_ADDRESS-1:0] init_addr;
  logic [OW-1:0]              outstanding;
  logic                       run, accept, pop, wr_run;
  logic [BYTES-1:0]           ram_we;
  logic [LOG_MAX_ADDRESS-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0]      ram_wdata;
  logic [DATA_WIDTH-1:0]      ram_q;
  logic [DATA_WIDTH-1:0]      mem [NUM_ADDRESSES];
  logic                       s0_v, s0_oor;
  logic [BYTES-1:0]           s0_byp_be;
  logic [DATA_WIDTH-1:0]      s0_byp_d, s0_d;
  logic                       push_v, fifo_valid;
  logic [DATA_WIDTH-1:0]      push_d, fifo_data;

  assign run        = (state_q == RUN);
  assign busy       = (state_q == INIT);
  assign read_ready = run && !rst && (outstanding < CAP);
  assign accept     = read && read_ready;
  assign pop        = valid_out && ready_in;
  assign wr_run     = run && write && ({1'b0, addr_write} < ADDR_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= (INIT_ON_RESET != 0) ? INIT : RUN;
      init_addr <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_addr <= init_addr + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (init_addr == LAST_ADDR) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // The sweep owns the single write port while it runs.
  always_comb begin
    ram_we    = '0;
    ram_waddr = addr_write;
    ram_wdata = data_write;
    if (busy) begin
      ram_we    = '1;
      ram_waddr = init_addr;
      ram_wdata = '0;
    end else if (wr_run) begin
      ram_we = be_write;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES; b++) begin
      if (ram_we[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    if (accept) ram_q <= mem[addr_read];
  end

  // The RAM read is read-first; a same-cycle write is merged in afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v      <= 1'b0;
      s0_oor    <= 1'b0;
      s0_byp_be <= '0;
      s0_byp_d  <= '0;
    end else begin
      s0_v      <= accept;
      s0_oor    <= !({1'b0, addr_read} < ADDR_LIMIT);
      s0_byp_be <= (wr_run && (addr_write == addr_read)) ? be_write : '0;
      s0_byp_d  <= data_write;
    end
  end

  always_comb begin
    s0_d = '0;
    if (!s0_oor) begin
      for (int b = 0; b < BYTES; b++) begin
        s0_d[8*b +: 8] = s0_byp_be[b] ? s0_byp_d[8*b +: 8] : ram_q[8*b +: 8];
      end
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_no_pad
      assign push_v = s0_v;
      assign push_d = s0_d;
    end else begin : g_pad
      logic [READ_LATENCY-2:0] pv;
      logic [DATA_WIDTH-1:0]   pd [READ_LATENCY-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pv <= '0;
          for (int i = 0; i < READ_LATENCY - 1; i++) pd[i] <= '0;
        end else begin
          pv[0] <= s0_v;
          pd[0] <= s0_d;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign push_v = pv[READ_LATENCY-2];
      assign push_d = pd[READ_LATENCY-2];
    end
  endgenerate

  mem_pipe_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_v),
    .push_data(push_d),
    .ready    (ready_in),
    .valid    (fifo_valid),
    .data     (fifo_data)
  );

  assign valid_out = fifo_valid;
  assign data_read = fifo_valid ? fifo_data : '0;

  // Reads in the pipeline plus words held in the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench for mem_pipe: init sweep, byte enables, bypass, stall, ordering, reset.
module tb_mem_pipe;

  localparam int DW = 32;
  localparam int NA = 1024;
  localparam int AW = 10;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_write;
  logic [3:0]    be_write;
  logic [AW-1:0] addr_write;
  logic          write;
  logic [AW-1:0] addr_read;
  logic          read;
  logic          read_ready;
  logic [DW-1:0] data_read;
  logic          valid_out;
  logic          ready_in;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  mem_pipe #(
    .DATA_WIDTH(DW), .NUM_ADDRESSES(NA), .LOG_MAX_ADDRESS(AW),
    .READ_LATENCY(RL), .INIT_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst), .data_write(data_write), .be_write(be_write),
    .addr_write(addr_write), .write(write), .addr_read(addr_read), .read(read),
    .read_ready(read_ready), .data_read(data_read), .valid_out(valid_out),
    .ready_in(ready_in), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int i);
    return {8'hA5, 8'(i), 8'(~i), 8'(i * 3)};
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    write = 1'b1; addr_write = a; data_write = d; be_write = be;
    step();
    write = 1'b0; be_write = 4'h0;
  endtask

  // Single read with ready_in=1; optional same-cycle write and a write in the following cycle.
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp,
                        input bit same_wr, input logic [31:0] sd, input logic [3:0] sbe,
                        input bit late_wr);
    chk1({tag, "_rdy"}, read_ready, 1'b1);
    read = 1'b1; addr_read = a;
    if (same_wr) begin
      write = 1'b1; addr_write = a; data_write = sd; be_write = sbe;
    end
    step();
    read = 1'b0; write = 1'b0;
    if (late_wr) begin
      write = 1'b1; addr_write = a; data_write = 32'h0BADF00D; be_write = 4'hF;
    end
    for (int k = 1; k < RL; k++) begin
      chk1({tag, "_early"}, valid_out, 1'b0);
      step();
      write = 1'b0;
    end
    chk1({tag, "_vld"}, valid_out, 1'b1);
    chk({tag, "_dat"}, data_read, exp);
    step();
  endtask

  task automatic run_init(input string tag);
    int  n;
    bit  seen_v;
    n = 0;
    seen_v = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      if (valid_out !== 1'b0) seen_v = 1'b1;
      if (n == 500) chk1({tag, "_rdy_low"}, read_ready, 1'b0);
      step();
    end
    chk({tag, "_busy_cycles"}, n, 32'd1024);
    chk1({tag, "_no_valid"}, seen_v, 1'b0);
  endtask

  initial begin
    int acc;
    int next_a;
    int rx;
    int cyc;
    int q[$];

    rst = 1'b1; write = 1'b0; read = 1'b0; be_write = 4'h0;
    data_write = '0; addr_write = '0; addr_read = '0; ready_in = 1'b1;
    step(); step(); step();
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_valid", valid_out, 1'b0);
    chk("rst_data", data_read, 32'h0);
    chk1("rst_rdy", read_ready, 1'b0);

    // Writes and reads held active during the sweep must be ignored.
    rst = 1'b0;
    write = 1'b1; addr_write = 10'd0; data_write = 32'hFFFFFFFF; be_write = 4'hF;
    read = 1'b1; addr_read = 10'd3;
    run_init("init");
    write = 1'b0; be_write = 4'h0; read = 1'b0;

    rd_chk("zero0", 10'd0, 32'h0, 0, 32'h0, 4'h0, 0);
    rd_chk("zero511", 10'd511, 32'h0, 0, 32'h0, 4'h0, 0);
    rd_chk("zero1023", 10'd1023, 32'h0, 0, 32'h0, 4'h0, 0);

    wr(10'd5, 32'hAABBCCDD, 4'hF);
    wr(10'd5, 32'h11223344, 4'h5);
    rd_chk("be_merge", 10'd5, 32'hAA22CC44, 0, 32'h0, 4'h0, 0);
    wr(10'd5, 32'h00000000, 4'h0);
    rd_chk("be_zero", 10'd5, 32'hAA22CC44, 0, 32'h0, 4'h0, 0);
    rd_chk("same_cyc", 10'd7, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'hF, 1);
    rd_chk("late_wr", 10'd7, 32'h0BADF00D, 0, 32'h0, 4'h0, 0);
    rd_chk("byp_part", 10'd5, 32'h5522CC44, 1, 32'h55000000, 4'h8, 0);
    rd_chk("byp_stored", 10'd5, 32'h5522CC44, 0, 32'h0, 4'h0, 0);

    for (int i = 0; i < 64; i++) wr(10'(i), pat(i), 4'hF);

    // Stall: only READ_LATENCY+1 reads fit.
    ready_in = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      read = 1'b1; addr_read = 10'(10 + i);
      if (read_ready === 1'b1) acc++;
      step();
    end
    read = 1'b0;
    chk("stall_accepted", acc, 32'(RL + 1));
    chk1("stall_rdy_low", read_ready, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk1("stall_hold_v", valid_out, 1'b1);
      chk("stall_hold_d", data_read, pat(10));
      step();
    end
    ready_in = 1'b1;
    chk1("pop_rdy_still_low", read_ready, 1'b0);
    chk("drain0", data_read, pat(10));
    step();
    chk("drain1", data_read, pat(11));
    step();
    chk("drain2", data_read, pat(12));
    step();
    chk1("drain_empty_v", valid_out, 1'b0);
    chk("drain_empty_d", data_read, 32'h0);
    chk1("drain_rdy", read_ready, 1'b1);

    // Back-to-back stream at one read per cycle.
    for (int k = 0; k < 10; k++) begin
      read = (k < 8); addr_read = 10'(k);
      if (k < 8) chk1("stream_rdy", read_ready, 1'b1);
      if (k >= RL) begin
        chk1("stream_v", valid_out, 1'b1);
        chk("stream_d", data_read, pat(k - RL));
      end else begin
        chk1("stream_idle", valid_out, 1'b0);
      end
      step();
    end
    read = 1'b0;
    step();

    // Random backpressure, reads 0..63 checked in order against a queue.
    next_a = 0; rx = 0; cyc = 0;
    while (rx < 64 && cyc < 3000) begin
      ready_in = 1'($urandom_range(0, 1));
      read = (next_a < 64);
      addr_read = 10'(next_a);
      if (valid_out === 1'b1) begin
        if (q.size() == 0) begin
          chk1("rnd_spurious", valid_out, 1'b0);
        end else begin
          chk("rnd_dat", data_read, pat(q[0]));
          if (ready_in) begin
            void'(q.pop_front());
            rx++;
          end
        end
      end else begin
        chk("rnd_zero", data_read, 32'h0);
      end
      if (read && read_ready === 1'b1) begin
        q.push_back(next_a);
        next_a++;
      end
      cyc++;
      step();
    end
    read = 1'b0; ready_in = 1'b1;
    chk("rnd_count", rx, 32'd64);

    // Reset with reads in flight.
    read = 1'b1; addr_read = 10'd20;
    step();
    addr_read = 10'd21;
    step();
    read = 1'b0;
    rst = 1'b1;
    #1;
    chk1("mid_rst_valid", valid_out, 1'b0);
    chk("mid_rst_data", data_read, 32'h0);
    chk1("mid_rst_busy", busy, 1'b1);
    chk1("mid_rst_rdy", read_ready, 1'b0);
    step(); step();
    rst = 1'b0;
    run_init("reinit");
    rd_chk("reinit_zero", 10'd21, 32'h0, 0, 32'h0, 4'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
